adder_bist: RTL

ADDER_BIST -- requirements
Module: adder_bist

---
 rtl/adder_bist_pkg.sv | 20 ++
 rtl/adder_bist_full_adder.sv | 17 +
 rtl/adder_bist.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg
//   Shared definitions for the full-adder built-in self test:
//   controller state encoding, vector count and width, default settle time.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int VEC_COUNT      = 8;
  localparam int VEC_W          = 3;
  localparam int SETTLE_DEFAULT = 2;
  // Settle counter width; covers the legal SETTLE range 0..15.
  localparam int CNT_W          = 4;

endpackage

// File: rtl/adder_bist_full_adder.sv
// full_adder
//   Reference one-bit full adder, used as the golden model inside adder_bist.
//   Ports:
//     a, b, cin  : operand bits and carry in
//     sum, carry : a^b^cin and majority(a,b,cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_bist.sv
// adder_bist
//   Exhaustive built-in self test for an external one-bit full adder.
//   On start it walks the vectors {a,b,cin} = 000..111. Each vector gets one
//   APPLY cycle, SETTLE WAIT cycles and one CHECK cycle. In CHECK the
//   external response is compared with a golden full_adder fed by the same
//   registered stimulus. Mismatches are counted, and the first one is captured.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     start                 : one-cycle run request (ignored while busy)
//     dut_a/dut_b/dut_cin   : registered stimulus to the adder under test
//     dut_sum/dut_carry     : response from the adder under test
//     busy, done, pass      : run status (all registered)
//     err_count             : saturating mismatch count for the current/last run
//     fail_valid            : at least one mismatch recorded
//     first_fail_vec        : {a,b,cin} of the first mismatching vector
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT,
  parameter int ERRW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  state_t             state;
  state_t             state_n;
  logic [VEC_W-1:0]   idx;
  logic [VEC_W-1:0]   vec_p0;
  logic [CNT_W-1:0]   wait_cnt;
  logic               gold_sum;
  logic               gold_carry;
  logic               accept;
  logic               mismatch;
  logic               last_vec;
  logic               wait_end;
  logic               in_run;
  logic               in_done;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    if (v == {ERRW{1'b1}}) begin
      return v;
    end
    return v + ERRW'(1);
  endfunction

  // Status outputs lag the state by one register. The busy term keeps a
  // start from being accepted during that one-cycle tail after the last
  // CHECK.
  assign accept   = start && !busy && (state == ST_IDLE || state == ST_DONE);
  assign last_vec = (idx == VEC_W'(VEC_COUNT - 1));
  assign wait_end = (wait_cnt == CNT_W'(SETTLE - 1));
  assign in_run   = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_CHECK);
  assign in_done  = (state == ST_DONE);
  assign mismatch = (dut_sum != gold_sum) || (dut_carry != gold_carry);

  assign dut_a   = vec_p0[2];
  assign dut_b   = vec_p0[1];
  assign dut_cin = vec_p0[0];

  full_adder u_gold (
    .a     (vec_p0[2]),
    .b     (vec_p0[1]),
    .cin   (vec_p0[0]),
    .sum   (gold_sum),
    .carry (gold_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_n = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_n = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (wait_end) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_n = last_vec ? ST_DONE : ST_APPLY;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // p0: stimulus register, settle counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      vec_p0         <= '0;
      wait_cnt       <= '0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      busy <= in_run;
      done <= in_done && !accept;
      pass <= in_done && !accept && (err_count == '0);
      case (state)
        ST_IDLE, ST_DONE: begin
          vec_p0 <= '0;
          if (accept) begin
            idx            <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        ST_APPLY: begin
          vec_p0   <= idx;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= vec_p0;
            end
          end
          if (!last_vec) begin
            idx <= idx + VEC_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
